// File: rtl/cdce62002_spi_config.sv
// rtl/cdce62002_spi_config.sv - writes two register words to a CDCE62002 over its
// LSB-first serial port, then waits for the PLL to report a stable lock.
module cdce62002_spi_config #(
    parameter logic [31:0] REG0_VALUE   = 32'h8184_0320,
    parameter logic [31:0] REG1_VALUE   = 32'h6000_0001,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned CS_GAP       = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic sysclk,
    input  logic reset_INV,
    input  logic start,
    input  logic pll_locked,
    output logic pll_spi_clk,
    output logic pll_spi_mosi,
    output logic pll_spi_cs_INV,
    output logic busy,
    output logic done,
    output logic error
);

    // The low nibble of each word is the CDCE62002 register address.
    localparam logic [31:0] WORD0    = {REG0_VALUE[31:4], 4'h0};
    localparam logic [31:0] WORD1    = {REG1_VALUE[31:4], 4'h1};
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_LATCH,
        S_WAIT_LOCK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic [7:0]  r_div;
    logic [7:0]  w_div;
    logic [4:0]  r_bit;
    logic [4:0]  w_bit;
    logic        r_word_sel;
    logic        w_word_sel;
    logic [15:0] r_tmo;
    logic [15:0] w_tmo;
    logic [3:0]  r_run;
    logic [3:0]  w_run;
    logic        r_spi_clk;
    logic        w_spi_clk;
    logic        r_mosi;
    logic        w_mosi;
    logic        r_cs_n;
    logic        w_cs_n;
    logic        r_busy;
    logic        w_busy;
    logic        r_done;
    logic        w_done;
    logic        r_error;
    logic        w_error;
    logic        r_lock_meta;
    logic        r_lock_sync;
    logic [31:0] w_cur_word;

    assign w_cur_word = r_word_sel ? WORD1 : WORD0;

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            r_div      <= 8'd0;
            r_bit      <= 5'd0;
            r_word_sel <= 1'b0;
            r_tmo      <= 16'd0;
            r_run      <= 4'd0;
            r_spi_clk  <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_div      <= w_div;
            r_bit      <= w_bit;
            r_word_sel <= w_word_sel;
            r_tmo      <= w_tmo;
            r_run      <= w_run;
            r_spi_clk  <= w_spi_clk;
            r_mosi     <= w_mosi;
            r_cs_n     <= w_cs_n;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_div      = r_div;
        w_bit      = r_bit;
        w_word_sel = r_word_sel;
        w_tmo      = r_tmo;
        w_run      = r_run;
        w_spi_clk  = r_spi_clk;
        w_mosi     = r_mosi;
        w_cs_n     = r_cs_n;
        w_busy     = r_busy;
        w_done     = r_done;
        w_error    = r_error;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    w_state    = S_SETUP;
                    w_word_sel = 1'b0;
                    w_div      = 8'd0;
                    w_busy     = 1'b1;
                    w_done     = 1'b0;
                    w_error    = 1'b0;
                    w_cs_n     = 1'b0;
                    w_spi_clk  = 1'b0;
                    w_mosi     = WORD0[0];
                end
            end

            // SETUP doubles as the low phase of bit 0, so SHIFT opens on a rising edge.
            S_SETUP: begin
                if (r_div == DIV_LAST) begin
                    w_state   = S_SHIFT;
                    w_div     = 8'd0;
                    w_bit     = 5'd0;
                    w_spi_clk = 1'b1;
                end else begin
                    w_div = r_div + 8'd1;
                end
            end

            S_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div = 8'd0;
                    if (r_spi_clk) begin
                        w_spi_clk = 1'b0;
                        if (r_bit == 5'd31) begin
                            w_state = S_LATCH;
                        end else begin
                            w_bit  = r_bit + 5'd1;
                            w_mosi = w_cur_word[r_bit + 5'd1];
                        end
                    end else begin
                        w_spi_clk = 1'b1;
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end

            // cs low for one half-period after the last bit, then the inter-word gap.
            S_LATCH: begin
                if (!r_cs_n) begin
                    if (r_div == DIV_LAST) begin
                        w_cs_n = 1'b1;
                        w_mosi = 1'b0;
                        w_div  = 8'd0;
                    end else begin
                        w_div = r_div + 8'd1;
                    end
                end else if (r_div == GAP_LAST) begin
                    w_div = 8'd0;
                    if (!r_word_sel) begin
                        w_state    = S_SETUP;
                        w_word_sel = 1'b1;
                        w_cs_n     = 1'b0;
                        w_mosi     = WORD1[0];
                    end else begin
                        w_state = S_WAIT_LOCK;
                        w_tmo   = 16'd0;
                        w_run   = 4'd0;
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end

            S_WAIT_LOCK: begin
                w_tmo = r_tmo + 16'd1;
                w_run = r_lock_sync ? r_run + 4'd1 : 4'd0;
                if (r_lock_sync && (r_run == 4'hF)) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else if (r_tmo == TMO_LAST) begin
                    w_state = S_FAIL;
                    w_busy  = 1'b0;
                    w_error = 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign pll_spi_clk    = r_spi_clk;
    assign pll_spi_mosi   = r_mosi;
    assign pll_spi_cs_INV = r_cs_n;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;

endmodule

// File: tb/tb_cdce62002_spi_config.sv
// tb/tb_cdce62002_spi_config.sv - directed self-checking bench for cdce62002_spi_config.
module tb_cdce62002_spi_config;

    logic sysclk = 1'b0;
    logic rst_n;
    logic start_a;
    logic start_b;
    logic lock_a;
    logic lock_b;

    logic a_clk, a_mosi, a_cs, a_busy, a_done, a_error;
    logic b_clk, b_mosi, b_cs, b_busy, b_done, b_error;

    always #5 sysclk = ~sysclk;

    cdce62002_spi_config u_dut_a (
        .sysclk        (sysclk),
        .reset_INV     (rst_n),
        .start         (start_a),
        .pll_locked    (lock_a),
        .pll_spi_clk   (a_clk),
        .pll_spi_mosi  (a_mosi),
        .pll_spi_cs_INV(a_cs),
        .busy          (a_busy),
        .done          (a_done),
        .error         (a_error)
    );

    cdce62002_spi_config #(
        .REG1_VALUE  (32'hFFFF_FFFF),
        .LOCK_TIMEOUT(100)
    ) u_dut_b (
        .sysclk        (sysclk),
        .reset_INV     (rst_n),
        .start         (start_b),
        .pll_locked    (lock_b),
        .pll_spi_clk   (b_clk),
        .pll_spi_mosi  (b_mosi),
        .pll_spi_cs_INV(b_cs),
        .busy          (b_busy),
        .done          (b_done),
        .error         (b_error)
    );

    // Monitors: PLL-side shift register, rising-edge count, cs-low and cs-high lengths.
    logic [31:0] a_cap = 32'd0;
    logic [31:0] b_cap = 32'd0;
    logic [31:0] a_words[$];
    logic [31:0] b_words[$];
    int          a_lows[$];
    int          a_gaps[$];
    int          a_rises = 0;
    int          a_low = 0;
    int          a_high = 0;

    always @(posedge a_clk) begin
        a_cap   = {a_mosi, a_cap[31:1]};
        a_rises = a_rises + 1;
    end

    always @(posedge a_cs) a_words.push_back(a_cap);

    always @(posedge b_clk) b_cap = {b_mosi, b_cap[31:1]};

    always @(posedge b_cs) b_words.push_back(b_cap);

    always @(negedge sysclk) begin
        if (a_cs === 1'b0) begin
            a_low = a_low + 1;
            if (a_high != 0) a_gaps.push_back(a_high);
            a_high = 0;
        end else begin
            a_high = a_high + 1;
            if (a_low != 0) a_lows.push_back(a_low);
            a_low = 0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    int n;
    int r0;
    int w0;
    int l0;
    int g0;

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        lock_a  = 1'b0;
        lock_b  = 1'b0;
        repeat (3) tick();
        chk("rst_clk",   32'(a_clk),   0);
        chk("rst_cs",    32'(a_cs),    1);
        chk("rst_mosi",  32'(a_mosi),  0);
        chk("rst_busy",  32'(a_busy),  0);
        chk("rst_done",  32'(a_done),  0);
        chk("rst_error", 32'(a_error), 0);
        rst_n = 1'b1;
        tick();

        // Default configuration with the PLL locked throughout.
        lock_a = 1'b1;
        r0 = a_rises;
        w0 = a_words.size();
        l0 = a_lows.size();
        g0 = a_gaps.size();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t1_setup_busy", 32'(a_busy), 1);
        chk("t1_setup_cs",   32'(a_cs),   0);
        chk("t1_setup_clk",  32'(a_clk),  0);
        n = 0;
        while (a_words.size() < w0 + 2 && n < 1000) begin tick(); n++; end
        chk("t1_word0", (a_words.size() > w0)     ? a_words[w0]     : 32'hDEAD_DEAD, 32'h8184_0320);
        chk("t1_word1", (a_words.size() > w0 + 1) ? a_words[w0 + 1] : 32'hDEAD_DEAD, 32'h6000_0001);
        chk("t1_low0",  (a_lows.size() > l0)      ? 32'(a_lows[l0])     : 32'd0, 130);
        chk("t1_low1",  (a_lows.size() > l0 + 1)  ? 32'(a_lows[l0 + 1]) : 32'd0, 130);
        chk("t1_gap",   (a_gaps.size() > g0 + 1)  ? 32'(a_gaps[g0 + 1]) : 32'd0, 4);
        n = 0;
        while (!a_done && n < 200) begin tick(); n++; end
        chk("t1_done_latency", 32'(n), 20);
        chk("t1_rises", 32'(a_rises - r0), 64);
        chk("t1_busy_clear", 32'(a_busy),  0);
        chk("t1_no_error",   32'(a_error), 0);
        lock_a = 1'b0;
        repeat (30) tick();
        chk("t1_done_holds", 32'(a_done), 1);

        // Lock chatters in 10-cycle runs, then goes steady.
        w0 = a_words.size();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("t2_done_cleared", 32'(a_done), 0);
        chk("t2_busy_set",     32'(a_busy), 1);
        n = 0;
        while (a_words.size() < w0 + 2 && n < 1000) begin tick(); n++; end
        for (int k = 0; k < 6; k++) begin
            lock_a = (k % 2 == 0);
            repeat (10) tick();
        end
        chk("t2_no_early_done", 32'(a_done), 0);
        lock_a = 1'b1;
        n = 0;
        while (!a_done && n < 200) begin tick(); n++; end
        chk("t2_done_latency", 32'(n), 18);

        // start held high through the whole transfer must not restart it.
        r0 = a_rises;
        w0 = a_words.size();
        start_a = 1'b1;
        tick();
        chk("t3_accept_busy", 32'(a_busy), 1);
        chk("t3_accept_done", 32'(a_done), 0);
        n = 0;
        while (a_words.size() < w0 + 2 && n < 1000) begin tick(); n++; end
        start_a = 1'b0;
        n = 0;
        while (!a_done && n < 200) begin tick(); n++; end
        chk("t3_done",  32'(a_done), 1);
        chk("t3_rises", 32'(a_rises - r0), 64);
        chk("t3_words", 32'(a_words.size() - w0), 2);

        // Reset after the 10th rising SPI clock aborts the word.
        r0 = a_rises;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (a_rises - r0 < 10 && n < 500) begin tick(); n++; end
        rst_n = 1'b0;
        #1;
        chk("t4_abort_clk", 32'(a_clk), 0);
        chk("t4_abort_cs",  32'(a_cs),  1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("t4_rises",   32'(a_rises - r0), 10);
        chk("t4_idle_busy", 32'(a_busy), 0);
        chk("t4_idle_cs",   32'(a_cs),   1);
        chk("t4_idle_done", 32'(a_done), 0);
        w0 = a_words.size();
        l0 = a_lows.size();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!a_done && n < 1000) begin tick(); n++; end
        chk("t4_restart_done", 32'(a_done), 1);
        chk("t4_word0", (a_words.size() > w0) ? a_words[w0] : 32'hDEAD_DEAD, 32'h8184_0320);
        chk("t4_low0",  (a_lows.size() > l0)  ? 32'(a_lows[l0]) : 32'd0, 130);

        // Second instance: all-ones register 1 and a short lock timeout.
        w0 = b_words.size();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (b_words.size() < w0 + 2 && n < 1000) begin tick(); n++; end
        chk("t5_word0", (b_words.size() > w0)     ? b_words[w0]     : 32'hDEAD_DEAD, 32'h8184_0320);
        chk("t5_word1", (b_words.size() > w0 + 1) ? b_words[w0 + 1] : 32'hDEAD_DEAD, 32'hFFFF_FFF1);
        n = 0;
        while (!b_error && n < 300) begin tick(); n++; end
        chk("t5_error_latency", 32'(n), 104);
        chk("t5_no_done", 32'(b_done), 0);
        chk("t5_no_busy", 32'(b_busy), 0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("t5_error_cleared", 32'(b_error), 0);
        chk("t5_busy_again",    32'(b_busy),  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
